// File: rtl/seven_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered digit data.
// Optional build macro SEVEN_HEX_EN enables A-F glyphs for nibbles 10-15 (blank otherwise).
module seven_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_tick
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PS_W  = $clog2(SCAN_DIV);
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [PS_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [4*DIGITS-1:0]  shadow_data_q, shadow_data_d;
   logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
   logic [4*DIGITS-1:0]  active_data_q, active_data_d;
   logic [DIGITS-1:0]    active_dp_q, active_dp_d;
   logic [7:0]           seg_q, seg_d;
   logic [DIGITS-1:0]    dig_q, dig_d;
   logic                 tick_q, tick_d;

   logic                 digit_tc;
   logic                 frame_wrap;
   logic                 zero_run;
   logic [DIGITS-1:0]    lz_blank;
   logic [3:0]           cur_nib;
   logic                 cur_dp;
   logic                 cur_blank;

   // Segment pattern g..a, active-low.
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
`ifdef SEVEN_HEX_EN
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         4'hF: g = 7'b0001110;
`endif
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   always_comb begin
      digit_tc      = 1'b0;
      frame_wrap    = 1'b0;
      presc_d       = presc_q;
      idx_d         = idx_q;
      shadow_data_d = shadow_data_q;
      shadow_dp_d   = shadow_dp_q;
      active_data_d = active_data_q;
      active_dp_d   = active_dp_q;
      tick_d        = 1'b0;
      zero_run      = 1'b1;
      lz_blank      = '0;
      cur_nib       = 4'h0;
      cur_dp        = 1'b0;
      cur_blank     = 1'b0;
      seg_d         = 8'hFF;
      dig_d         = '1;

      if (enable) begin
         digit_tc   = (presc_q == PS_LAST);
         frame_wrap = digit_tc && (idx_q == IDX_LAST);
         presc_d    = digit_tc ? '0 : presc_q + 1'b1;
         if (digit_tc) begin
            idx_d = frame_wrap ? '0 : idx_q + 1'b1;
         end
      end
      tick_d = frame_wrap;

      if (load) begin
         shadow_data_d = data_in;
         shadow_dp_d   = dp_in;
      end
      // A load landing on the frame boundary bypasses the shadow so it is not a frame late.
      if (frame_wrap) begin
         active_data_d = load ? data_in : shadow_data_q;
         active_dp_d   = load ? dp_in   : shadow_dp_q;
      end

      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_run    = zero_run & (active_data_q[4*k +: 4] == 4'h0);
         lz_blank[k] = blank_lz & zero_run;
      end

      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_nib   = active_data_q[4*k +: 4];
            cur_dp    = active_dp_q[k];
            cur_blank = lz_blank[k];
         end
      end

      if (enable) begin
         seg_d = {~cur_dp, cur_blank ? 7'b1111111 : glyph(cur_nib)};
         for (int k = 0; k < DIGITS; k++) begin
            dig_d[k] = (idx_q != IDX_W'(k));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q       <= '0;
         idx_q         <= '0;
         shadow_data_q <= '0;
         shadow_dp_q   <= '0;
         active_data_q <= '0;
         active_dp_q   <= '0;
         seg_q         <= 8'hFF;
         dig_q         <= '1;
         tick_q        <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         shadow_data_q <= shadow_data_d;
         shadow_dp_q   <= shadow_dp_d;
         active_data_q <= active_data_d;
         active_dp_q   <= active_dp_d;
         seg_q         <= seg_d;
         dig_q         <= dig_d;
         tick_q        <= tick_d;
      end
   end

   assign seg_out    = seg_q;
   assign dig_sel    = dig_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_scan_driver.sv
// Directed bench for seven_scan_driver with DIGITS=4, SCAN_DIV=4 (16-cycle frames).
module tb_seven_scan_driver;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        load;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [7:0]  seg_out;
   logic [3:0]  dig_sel;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

`ifdef SEVEN_HEX_EN
   localparam logic [7:0] SEG_A = 8'h88;
   localparam logic [7:0] SEG_F = 8'h8E;
`else
   localparam logic [7:0] SEG_A = 8'hFF;
   localparam logic [7:0] SEG_F = 8'hFF;
`endif

   typedef struct {
      logic [15:0]      data;
      logic [3:0]       dp;
      logic             blz;
      logic [3:0][7:0]  exp;   // exp[d] = seg_out while digit d is selected
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   seven_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .seg_out    (seg_out),
      .dig_sel    (dig_sel),
      .frame_tick (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string nm, input logic [7:0] eseg, input logic [3:0] edig,
                          input logic etick);
      chk({nm, "_seg"}, seg_out, eseg);
      chk({nm, "_dig"}, {4'h0, dig_sel}, {4'h0, edig});
      chk({nm, "_tick"}, {7'h0, frame_tick}, {7'h0, etick});
   endtask

   task automatic wait_frame(input int budget, output int n);
      n = 0;
      while (frame_tick !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (frame_tick !== 1'b1) begin
         errors++;
         $display("FAIL frame_wait: no frame_tick within %0d cycles", budget);
      end
   endtask

   // Starts on a frame_tick cycle, ends on the next one; optional mid-frame load.
   task automatic check_frame(input logic [3:0][7:0] exp, input bit inj,
                              input logic [15:0] nd, input logic [3:0] ndp);
      logic [3:0] ed;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            ed = 4'b1111;
            ed[d] = 1'b0;
            chk_out("frame", exp[d], ed, (d == 3 && c == 3));
            if (inj && d == 1 && c == 1) begin
               load    = 1'b1;
               data_in = nd;
               dp_in   = ndp;
            end else begin
               load = 1'b0;
            end
         end
      end
   endtask

   initial begin
      int n;
      logic [15:0] nd;
      logic [3:0]  ndp;

      vecs[0] = '{16'h1234, 4'b0100, 1'b0, {8'hF9, 8'h24, 8'hB0, 8'h99}};
      vecs[1] = '{16'h0050, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
      vecs[3] = '{16'h0000, 4'b1010, 1'b1, {8'h7F, 8'hFF, 8'h7F, 8'hC0}};
      vecs[4] = '{16'h5678, 4'b0001, 1'b0, {8'h92, 8'h82, 8'hF8, 8'h00}};
      vecs[5] = '{16'h090A, 4'b0000, 1'b1, {8'hFF, 8'h90, 8'hC0, SEG_A}};
      vecs[6] = '{16'h0F00, 4'b0000, 1'b1, {8'hFF, SEG_F, 8'hC0, 8'hC0}};
      vecs[7] = '{16'h9000, 4'b0000, 1'b1, {8'h90, 8'hC0, 8'hC0, 8'hC0}};

      rst      = 1'b1;
      enable   = 1'b0;
      load     = 1'b0;
      data_in  = 16'h0;
      dp_in    = 4'h0;
      blank_lz = 1'b0;
      repeat (3) step();
      chk_out("reset", 8'hFF, 4'b1111, 1'b0);

      // Release with the first record loaded mid-frame; display stays at zeros.
      rst     = 1'b0;
      enable  = 1'b1;
      load    = 1'b1;
      data_in = vecs[0].data;
      dp_in   = vecs[0].dp;
      step();
      load = 1'b0;
      chk_out("first_digit", 8'hC0, 4'b1110, 1'b0);
      wait_frame(40, n);
      chk("first_frame_len", 8'(n), 8'd15);

      for (int i = 0; i < NV; i++) begin
         blank_lz = vecs[i].blz;
         nd  = (i < NV - 1) ? vecs[(i + 1) % NV].data : 16'h0;
         ndp = (i < NV - 1) ? vecs[(i + 1) % NV].dp   : 4'h0;
         check_frame(vecs[i].exp, (i < NV - 1), nd, ndp);
      end

      // Load in the terminal-count cycle reaches the display in the very next frame.
      blank_lz = 1'b0;
      repeat (15) step();
      load    = 1'b1;
      data_in = 16'h4321;
      dp_in   = 4'b0000;
      step();
      load = 1'b0;
      chk("boundary_tick", {7'h0, frame_tick}, 8'h01);
      check_frame({8'h99, 8'hB0, 8'hA4, 8'hF9}, 1'b0, 16'h0, 4'h0);

      // Pause one cycle into digit 1, then resume with the remaining prescaler count.
      repeat (5) step();
      chk_out("pre_pause", 8'hA4, 4'b1101, 1'b0);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_out("paused", 8'hFF, 4'b1111, 1'b0);
      end
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("resumed", 8'hA4, 4'b1101, 1'b0);
      end
      step();
      chk_out("next_digit", 8'hB0, 4'b1011, 1'b0);
      wait_frame(40, n);
      chk("resume_to_tick", 8'(n), 8'd7);

      // Mid-frame reset discards a pending shadow load.
      repeat (3) step();
      load    = 1'b1;
      data_in = 16'h7777;
      dp_in   = 4'b1111;
      step();
      load = 1'b0;
      step();
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_out("async_reset", 8'hFF, 4'b1111, 1'b0);
      step();
      chk_out("in_reset", 8'hFF, 4'b1111, 1'b0);
      rst = 1'b0;
      step();
      chk_out("post_reset", 8'hC0, 4'b1110, 1'b0);
      wait_frame(40, n);
      chk("post_reset_len", 8'(n), 8'd15);
      check_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0}, 1'b0, 16'h0, 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
